rect_hit_tree: RTL and testbench
================================

Name: rect_hit_tree

Overview:
- Pipelined hit-test and priority selector for the rectangle GPU.
- Compares one pixel coordinate against every rectangle's bounds in parallel.
- Reduces the per-rectangle hit flags through a registered binary tree of 2:1 priority muxes.
- Outputs whether any rectangle covers the pixel and the index of the topmost one. The colour lookup downstream uses that index.

Parameters:
- LEVELS, 6, tree depth; rectangle count N = 2**LEVELS (64).
- COORD_WIDTH, 16, width of coordinates and bounds (unsigned).

Ports:
- pixel_clk  in  1  clock; pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- x_coord  in  COORD_WIDTH  current pixel x.
- y_coord  in  COORD_WIDTH  current pixel y.
- rect_lefts  in  N*COORD_WIDTH  flattened; slice i = left edge of rect i.
- rect_tops  in  N*COORD_WIDTH  flattened top edges.
- rect_rights  in  N*COORD_WIDTH  flattened right edges (left+width, precomputed upstream).
- rect_bottoms  in  N*COORD_WIDTH  flattened bottom edges (top+height).
- hit  out  1  some rectangle covers the pixel (6 cycles earlier).
- hit_idx  out  LEVELS  index of winning rectangle; 0 when hit=0.

Behaviour:
- Hit test (combinational, per rect i): hit_i = (left_i <= x) && (x < right_i) && (top_i <= y) && (y < bottom_i).
  - All compares are unsigned at COORD_WIDTH.
  - Left/top are inclusive; right/bottom are exclusive.
  - A zero width or zero height, or right<left (wrapped sum), never hits.
- Tree: level 1 has N/2 nodes, each combining leaves 2k (low) and 2k+1 (high). Level L combines pairs of level L-1 outputs, with the same ordering.
- Each node computes:
  - flag = flag_lo | flag_hi.
  - idx = flag_hi ? idx_hi : idx_lo.
  - The higher index wins, so later rectangles are drawn on top.
  - Leaf idx is the constant i, generated internally; there is no data input.
- Every level's flag and idx are registered on the rising edge of pixel_clk. That gives LEVELS register stages.
- Comparators feed level 1 without a register.
- Latency: coordinates and bounds sampled at edge k appear on hit/hit_idx after edge k+LEVELS-1. That is valid during the cycle following the LEVELS-th edge counting the sampling edge, i.e. 6 cycles of latency.
- Throughput: one pixel per clock; fully pipelined, no stalls, no handshake.
- Reset: all pipeline flags and indices clear to 0 asynchronously while reset_n=0. Outputs then read hit=0, hit_idx=0 until valid data propagates (6 edges after release).
- When no rectangle hits, the tree yields hit=0 and hit_idx=0. The low-side default propagates; no special case is needed.
- Bounds are treated as stable per frame but sampled every cycle; a bound change mid-line takes effect with the same 6-cycle latency.
- All rectangles at identical bounds: hit_idx = N-1.

Decomposition:
- Shared package gpu_pkg holds COORD_WIDTH, LEVELS, RECT_COUNT = 2**LEVELS and DEFAULT_COLOR (16'hF800, used downstream).
- One natural sub-module: prio_node, a registered 2:1 priority combiner with pixel_clk/reset_n.
  - Inputs: flag_lo, idx_lo, flag_hi, idx_hi.
  - Outputs: registered flag, idx.
  - Instantiated via nested generate per level.
- Comparator logic is inline in a generate loop.

Test Plan:
- Reset: hold reset_n=0 with rect0 = [0,0)-[10,10) and x=y=5 → hit=0, hit_idx=0 throughout reset. After release, hit=1 and hit_idx=0 appear exactly 6 edges later.
- Bounds edges: rect3 = left 10, top 20, right 30, bottom 40; all others zero-size.
  - (10,20) → hit=1, idx=3.
  - (29,39) → hit=1, idx=3.
  - (30,20) → hit=0.
  - (10,40) → hit=0.
  - (9,25) → hit=0.
- Priority: rects 5, 17 and 63 all cover (100,100) → hit_idx=63. Shrink rect63 away → 17. Remove 17 → 5.
- Pipelining: stream x=0..15 on consecutive cycles with rect7 = [4,8)x[0,1), y=0 → hit high for exactly the 4 cycles whose outputs correspond to x=4..7, starting 6 cycles after x=4 is applied; idx=7.
- Degenerate: rect2 left=50, right=50 (zero width) → never hits. rect4 left=0, right=65535, top=0, bottom=65535 → hits every coordinate except x or y = 65535.
- Async reset mid-stream: assert reset_n=0 between edges while hit=1 → hit and hit_idx drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared constants for the rectangle GPU.
//   COORD_WIDTH   : width of pixel coordinates and rectangle bounds (unsigned)
//   LEVELS        : depth of the hit-priority tree
//   RECT_COUNT    : number of rectangles, 2**LEVELS
//   DEFAULT_COLOR : background colour used by the downstream colour lookup
package gpu_pkg;

    localparam int COORD_WIDTH = 16;
    localparam int LEVELS      = 6;
    localparam int RECT_COUNT  = 2 ** LEVELS;

    localparam logic [15:0] DEFAULT_COLOR = 16'hF800;

    typedef logic [COORD_WIDTH-1:0] coord_t;
    typedef logic [LEVELS-1:0]      rect_idx_t;

endpackage

// File: rtl/rect_hit_tree_if.sv
// Pixel/bounds bus into the hit-test tree and its hit result.
//   master : drives x_coord, y_coord, rect_* bounds; receives hit, hit_idx
//   slave  : the hit tree; receives coordinates and bounds, drives hit, hit_idx
// Bounds are flattened: slice i ([i*COORD_WIDTH +: COORD_WIDTH]) belongs to rect i.
interface rect_hit_tree_if #(
    parameter int LEVELS      = gpu_pkg::LEVELS,
    parameter int COORD_WIDTH = gpu_pkg::COORD_WIDTH
);
    localparam int N = 2 ** LEVELS;

    logic [COORD_WIDTH-1:0]   x_coord;
    logic [COORD_WIDTH-1:0]   y_coord;
    logic [N*COORD_WIDTH-1:0] rect_lefts;
    logic [N*COORD_WIDTH-1:0] rect_tops;
    logic [N*COORD_WIDTH-1:0] rect_rights;
    logic [N*COORD_WIDTH-1:0] rect_bottoms;
    logic                     hit;
    logic [LEVELS-1:0]        hit_idx;

    modport master (
        output x_coord, y_coord, rect_lefts, rect_tops, rect_rights, rect_bottoms,
        input  hit, hit_idx
    );

    modport slave (
        input  x_coord, y_coord, rect_lefts, rect_tops, rect_rights, rect_bottoms,
        output hit, hit_idx
    );

endinterface

// File: rtl/rect_hit_tree_prio_node.sv
// prio_node: registered 2:1 priority combiner, one node of the hit tree.
//   pixel_clk, reset_n : clock, asynchronous active-low reset
//   flag_lo, idx_lo    : result from the lower-indexed subtree
//   flag_hi, idx_hi    : result from the higher-indexed subtree
//   flag, idx          : registered combined result; the high side wins ties
module prio_node
    import gpu_pkg::*;
#(
    parameter int IDX_WIDTH = LEVELS
) (
    input  logic                 pixel_clk,
    input  logic                 reset_n,
    input  logic                 flag_lo,
    input  logic [IDX_WIDTH-1:0] idx_lo,
    input  logic                 flag_hi,
    input  logic [IDX_WIDTH-1:0] idx_hi,
    output logic                 flag,
    output logic [IDX_WIDTH-1:0] idx
);

    // When neither side hits, idx follows the low side; down the leftmost
    // chain that is leaf 0, so an empty tree reports index 0 for free.
    // NOTE: state registers use <= so every node samples its children's
    // pre-edge values; = would let a level see the same edge's new data.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            flag <= 1'b0;
            idx  <= '0;
        end else begin
            flag <= flag_lo | flag_hi;
            idx  <= flag_hi ? idx_hi : idx_lo;
        end
    end

endmodule

// File: rtl/rect_hit_tree.sv
// rect_hit_tree: pipelined hit test and topmost-rectangle selector.
//   pixel_clk : pixel clock
//   reset_n   : asynchronous active-low reset, clears every pipeline stage
//   bus       : slave side of rect_hit_tree_if (coordinates, bounds in;
//               hit, hit_idx out, LEVELS cycles after sampling)
// Each rectangle is tested combinationally against the pixel; the hit flags
// are then reduced by a registered binary tree in which the higher rectangle
// index wins, so later rectangles are drawn on top.
module rect_hit_tree #(
    parameter int LEVELS      = gpu_pkg::LEVELS,
    parameter int COORD_WIDTH = gpu_pkg::COORD_WIDTH
) (
    input  logic           pixel_clk,
    input  logic           reset_n,
    rect_hit_tree_if.slave bus
);

    localparam int N = 2 ** LEVELS;

    // Heap layout: node j combines nodes 2j (low) and 2j+1 (high).
    // Leaves N..2N-1 are the per-rectangle hit tests, node 1 is the root.
    logic [2*N-1:1]    node_flag;
    logic [LEVELS-1:0] node_idx [1:2*N-1];

    for (genvar i = 0; i < N; i++) begin : g_leaf
        logic [COORD_WIDTH-1:0] left, top, right, bottom;

        assign left   = bus.rect_lefts  [i*COORD_WIDTH +: COORD_WIDTH];
        assign top    = bus.rect_tops   [i*COORD_WIDTH +: COORD_WIDTH];
        assign right  = bus.rect_rights [i*COORD_WIDTH +: COORD_WIDTH];
        assign bottom = bus.rect_bottoms[i*COORD_WIDTH +: COORD_WIDTH];

        // Half-open box: zero-size or wrapped (right<left) bounds can never
        // satisfy both compares, so no explicit degenerate check is needed.
        assign node_flag[N+i] = (left <= bus.x_coord) && (bus.x_coord < right) &&
                                (top  <= bus.y_coord) && (bus.y_coord < bottom);
        assign node_idx[N+i]  = LEVELS'(i);
    end

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_level
        for (genvar k = 0; k < (N >> lv); k++) begin : g_node
            localparam int J = (N >> lv) + k;

            prio_node #(
                .IDX_WIDTH (LEVELS)
            ) u_node (
                .pixel_clk (pixel_clk),
                .reset_n   (reset_n),
                .flag_lo   (node_flag[2*J]),
                .idx_lo    (node_idx[2*J]),
                .flag_hi   (node_flag[2*J+1]),
                .idx_hi    (node_idx[2*J+1]),
                .flag      (node_flag[J]),
                .idx       (node_idx[J])
            );
        end
    end

    assign bus.hit     = node_flag[1];
    assign bus.hit_idx = node_idx[1];

endmodule

// File: tb/tb_rect_hit_tree.sv
// Directed testbench for rect_hit_tree: reset behaviour, bound edges,
// priority ordering, streaming latency, degenerate rectangles and
// asynchronous reset assertion.
module tb_rect_hit_tree;

    localparam int CW      = 16;
    localparam int LAT     = 6;
    localparam int N       = 64;

    logic pixel_clk = 1'b0;
    logic reset_n   = 1'b0;

    int tests = 0;
    int fails = 0;

    rect_hit_tree_if bus ();

    rect_hit_tree dut (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .bus       (bus.slave)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic exp_hit, input logic [5:0] exp_idx);
        tests++;
        assert (bus.hit === exp_hit && bus.hit_idx === exp_idx)
        else begin
            fails++;
            $error("FAIL %s: got hit=%0b idx=%0d, expected hit=%0b idx=%0d",
                   tag, bus.hit, bus.hit_idx, exp_hit, exp_idx);
        end
    endtask

    task automatic set_rect(input int i, input int l, input int t, input int r, input int b);
        bus.rect_lefts  [i*CW +: CW] = CW'(l);
        bus.rect_tops   [i*CW +: CW] = CW'(t);
        bus.rect_rights [i*CW +: CW] = CW'(r);
        bus.rect_bottoms[i*CW +: CW] = CW'(b);
    endtask

    task automatic clear_rects();
        bus.rect_lefts   = '0;
        bus.rect_tops    = '0;
        bus.rect_rights  = '0;
        bus.rect_bottoms = '0;
    endtask

    // Drive a pixel at a negedge, let it travel the full pipeline, and leave
    // the bench on the negedge after the result became visible.
    task automatic run_pixel(input int x, input int y);
        bus.x_coord = CW'(x);
        bus.y_coord = CW'(y);
        repeat (LAT) @(posedge pixel_clk);
        @(negedge pixel_clk);
    endtask

    initial begin
        clear_rects();
        bus.x_coord = '0;
        bus.y_coord = '0;

        // Reset: outputs stay clear while reset_n is low, then rect0 appears
        // exactly LAT edges after release.
        set_rect(0, 0, 0, 10, 10);
        bus.x_coord = 16'd5;
        bus.y_coord = 16'd5;
        repeat (3) @(negedge pixel_clk);
        check("reset_hold_a", 1'b0, 6'd0);
        repeat (4) @(negedge pixel_clk);
        check("reset_hold_b", 1'b0, 6'd0);
        reset_n = 1'b1;
        repeat (LAT - 1) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check("reset_edge5_still_0", 1'b0, 6'd0);
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        check("reset_edge6_hit", 1'b1, 6'd0);

        // Bound edges on rect3: left/top inclusive, right/bottom exclusive.
        clear_rects();
        set_rect(3, 10, 20, 30, 40);
        run_pixel(10, 20); check("edge_top_left",     1'b1, 6'd3);
        run_pixel(29, 39); check("edge_bottom_right", 1'b1, 6'd3);
        run_pixel(30, 20); check("edge_right_excl",   1'b0, 6'd0);
        run_pixel(10, 40); check("edge_bottom_excl",  1'b0, 6'd0);
        run_pixel(9, 25);  check("edge_left_outside", 1'b0, 6'd0);

        // Priority: the highest covering index wins.
        clear_rects();
        set_rect(5,  90, 90, 110, 110);
        set_rect(17, 90, 90, 110, 110);
        set_rect(63, 90, 90, 110, 110);
        run_pixel(100, 100); check("prio_63", 1'b1, 6'd63);
        set_rect(63, 90, 90, 100, 110);
        run_pixel(100, 100); check("prio_17", 1'b1, 6'd17);
        set_rect(17, 0, 0, 0, 0);
        run_pixel(100, 100); check("prio_5", 1'b1, 6'd5);

        // All rectangles identical: topmost is N-1.
        for (int i = 0; i < N; i++) set_rect(i, 0, 0, 8, 8);
        run_pixel(3, 3); check("prio_all_same", 1'b1, 6'd63);

        // Streaming: one x per cycle; the result for x=j shows up at the
        // negedge LAT cycles after it was driven.
        clear_rects();
        set_rect(7, 4, 0, 8, 1);
        run_pixel(0, 0);
        for (int c = 0; c < 16 + LAT; c++) begin
            int  j;
            bit  exp_hit;
            j       = c - LAT;
            exp_hit = (j >= 4 && j <= 7);
            check($sformatf("stream_c%0d", c), exp_hit, exp_hit ? 6'd7 : 6'd0);
            if (c < 16) bus.x_coord = CW'(c);
            @(negedge pixel_clk);
        end

        // Degenerate rectangles: zero width and wrapped bounds never hit.
        clear_rects();
        set_rect(2, 50, 0, 50, 100);
        run_pixel(50, 10); check("zero_width_at", 1'b0, 6'd0);
        run_pixel(49, 10); check("zero_width_left", 1'b0, 6'd0);
        set_rect(2, 60, 0, 20, 100);
        run_pixel(40, 10); check("wrapped_right", 1'b0, 6'd0);

        // Near-full-screen rect4 covers everything except coordinate 65535.
        clear_rects();
        set_rect(4, 0, 0, 65535, 65535);
        run_pixel(65535, 5); check("full_x_max", 1'b0, 6'd0);
        run_pixel(5, 65535); check("full_y_max", 1'b0, 6'd0);
        run_pixel(65534, 65534); check("full_corner", 1'b1, 6'd4);
        run_pixel(0, 0); check("full_origin", 1'b1, 6'd4);

        // Asynchronous reset between clock edges clears outputs at once.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_now", 1'b0, 6'd0);
        @(posedge pixel_clk);
        #1;
        check("async_reset_held", 1'b0, 6'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge pixel_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
